heading_steer: RTL and testbench

//  Downstream of the heading judge. Consumes its one-cycle ready pulse, 3-bit grade and signed

---
 rtl/heading_steer_if.sv | 25 ++
 rtl/heading_steer.sv | 126 ++++++++++++
 tb/tb_heading_steer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/heading_steer_if.sv
// Judge-to-steer bundle: judge result pulse plus tick in, heading/status out.
// The score signal exists only when STEER_SCORE_EN is defined.
interface heading_steer_if;
    logic               judge_ready;
    logic        [2:0]  judge_out;
    logic signed [15:0] judge_modi;
    logic               tick;
    logic        [15:0] heading;
    logic               busy;
    logic               done;
    logic               overrun;
`ifdef STEER_SCORE_EN
    logic        [15:0] score;

    modport master (output judge_ready, judge_out, judge_modi, tick,
                    input  heading, busy, done, overrun, score);
    modport slave  (input  judge_ready, judge_out, judge_modi, tick,
                    output heading, busy, done, overrun, score);
`else
    modport master (output judge_ready, judge_out, judge_modi, tick,
                    input  heading, busy, done, overrun);
    modport slave  (input  judge_ready, judge_out, judge_modi, tick,
                    output heading, busy, done, overrun);
`endif
endinterface

// File: rtl/heading_steer.sv
// Rotates the heading toward a judged correction by at most MAX_STEP degrees per tick.
// Optional STEER_SCORE_EN adds a saturating alignment score.
module heading_steer #(
    parameter int MAX_STEP     = 5,
    parameter int INIT_HEADING = 0
) (
    input  logic            clk,
    input  logic            rst,
    heading_steer_if.slave  steer
);
    typedef enum logic {IDLE, STEER} state_t;

    localparam logic signed [15:0] LIM    = 16'sd359;
    localparam logic signed [15:0] MAX_S  = 16'(MAX_STEP);
    localparam logic        [15:0] INIT_H = 16'(INIT_HEADING);

    state_t             state, state_n;
    logic        [15:0] heading_r, heading_n;
    logic signed [15:0] rem, rem_n;
    logic               busy_r, busy_n;
    logic               done_r, done_n;
    logic               overrun_r, overrun_n;
    logic signed [15:0] clamped;
    logic signed [15:0] step;
    logic signed [16:0] sum;

    function automatic logic signed [15:0] clamp_modi(input logic signed [15:0] v);
        if (v > LIM)  return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    // Step never exceeds 359, so a single correction brings the sum back into 0..359.
    function automatic logic [15:0] wrap_heading(input logic signed [16:0] s);
        if (s >= 17'sd360) return 16'(s - 17'sd360);
        if (s < 17'sd0)    return 16'(s + 17'sd360);
        return 16'(s);
    endfunction

    assign clamped = clamp_modi(steer.judge_modi);

    always_comb begin
        if (rem > MAX_S)       step = MAX_S;
        else if (rem < -MAX_S) step = -MAX_S;
        else                   step = rem;
    end

    assign sum = $signed({1'b0, heading_r}) + $signed({step[15], step});

    always_comb begin
        state_n   = state;
        heading_n = heading_r;
        rem_n     = rem;
        busy_n    = busy_r;
        done_n    = 1'b0;
        overrun_n = 1'b0;
        if (steer.judge_ready) begin
            // A new correction always wins over a pending tick.
            rem_n     = clamped;
            overrun_n = (state == STEER);
            if (clamped == 16'sd0) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end else begin
                state_n = STEER;
                busy_n  = 1'b1;
            end
        end else if (state == STEER && steer.tick) begin
            heading_n = wrap_heading(sum);
            rem_n     = rem - step;
            if (rem == step) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            heading_r <= INIT_H;
            rem       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state     <= state_n;
            heading_r <= heading_n;
            rem       <= rem_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            overrun_r <= overrun_n;
        end
    end

    assign steer.heading = heading_r;
    assign steer.busy    = busy_r;
    assign steer.done    = done_r;
    assign steer.overrun = overrun_r;

`ifdef STEER_SCORE_EN
    logic [15:0] score_r;
    logic        unused_grade;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] w);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, w};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            score_r <= '0;
        else if (steer.judge_ready)
            score_r <= sat_add(score_r, 2'd3 - steer.judge_out[1:0]);
    end

    assign steer.score  = score_r;
    assign unused_grade = steer.judge_out[2];
`else
    logic unused_grade;
    assign unused_grade = ^steer.judge_out;
`endif
endmodule

// File: tb/tb_heading_steer.sv
// Self-checking bench for heading_steer: directed spec scenarios plus random traffic
// checked against an integer-arithmetic model of heading and pending correction.
module tb_heading_steer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int m_head  = 0;
    int m_pend  = 0;
    int m_score = 0;
    bit m_busy  = 0;
    bit m_done  = 0;
    bit m_ovr   = 0;

    heading_steer_if ifc();

    heading_steer #(.MAX_STEP(5), .INIT_HEADING(0)) dut (
        .clk   (clk),
        .rst   (rst),
        .steer (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v);
        if (v > 359)  return 359;
        if (v < -359) return -359;
        return v;
    endfunction

    // Reference: pending correction as a plain integer, heading as a modulo-360 angle.
    task automatic model_edge(input bit rs, input bit jr, input logic [2:0] jo,
                              input int jm, input bit tk);
        int mv;
        m_done = 0;
        m_ovr  = 0;
        if (rs) begin
            m_head = 0; m_pend = 0; m_busy = 0; m_score = 0;
            return;
        end
        if (jr) begin
            m_ovr   = m_busy;
            m_pend  = clampi(jm);
            m_score = m_score + 3 - int'(jo[1:0]);
            if (m_score > 65535) m_score = 65535;
            m_busy  = (m_pend != 0);
            m_done  = (m_pend == 0);
        end else if (tk && m_busy) begin
            mv     = (m_pend > 0) ? ((m_pend < 5) ? m_pend : 5)
                                  : ((-m_pend < 5) ? m_pend : -5);
            m_head = ((m_head + mv) % 360 + 360) % 360;
            m_pend = m_pend - mv;
            if (m_pend == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic cyc(input bit rs, input bit jr, input logic [2:0] jo,
                       input int jm, input bit tk);
        rst             = rs;
        ifc.judge_ready = jr;
        ifc.judge_out   = jo;
        ifc.judge_modi  = 16'(jm);
        ifc.tick        = tk;
        model_edge(rs, jr, jo, jm, tk);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        ifc.judge_ready = 1'b0;
        ifc.tick        = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1, 0, 3'd0, 0, 0);
        cyc(1, 0, 3'd0, 0, 1);
        total++;
        if (ifc.heading !== 16'd0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset got h=%0d b=%0b d=%0b o=%0b want h=0 b=0 d=0 o=0",
                     ifc.heading, ifc.busy, ifc.done, ifc.overrun);
        end
`ifdef STEER_SCORE_EN
        total++;
        if (ifc.score !== 16'd0) begin
            bad++;
            $display("FAIL reset_score got=%0d want=0", ifc.score);
        end
`endif
    endtask

    task automatic test_cw();
        int e[3] = '{5, 10, 12};
        cyc(0, 1, 3'd0, 12, 0);
        total++;
        if (ifc.busy !== 1'b1 || ifc.done !== 1'b0 || ifc.heading !== 16'd0) begin
            bad++;
            $display("FAIL cw_load got b=%0b d=%0b h=%0d want b=1 d=0 h=0", ifc.busy, ifc.done, ifc.heading);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 3'd0, 0, 1);
            total++;
            if (ifc.heading !== 16'(e[i]) || ifc.done !== (i == 2) || ifc.busy !== (i != 2)) begin
                bad++;
                $display("FAIL cw_tick%0d got h=%0d d=%0b b=%0b want h=%0d d=%0b b=%0b",
                         i, ifc.heading, ifc.done, ifc.busy, e[i], (i == 2), (i != 2));
            end
        end
    endtask

    task automatic test_wrap();
        int e1[5] = '{7, 2, 357, 352, 350};
        int e2[4] = '{355, 0, 5, 10};
        cyc(0, 1, 3'd1, -22, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 3'd0, 0, 1);
            total++;
            if (ifc.heading !== 16'(e1[i]) || ifc.done !== (i == 4)) begin
                bad++;
                $display("FAIL wrap_down%0d got h=%0d d=%0b want h=%0d d=%0b",
                         i, ifc.heading, ifc.done, e1[i], (i == 4));
            end
        end
        cyc(0, 1, 3'd0, 20, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 3'd0, 0, 1);
            total++;
            if (ifc.heading !== 16'(e2[i]) || ifc.done !== (i == 3)) begin
                bad++;
                $display("FAIL wrap_up%0d got h=%0d d=%0b want h=%0d d=%0b",
                         i, ifc.heading, ifc.done, e2[i], (i == 3));
            end
        end
    endtask

    task automatic test_ccw();
        int e[4] = '{5, 3, 358, 353};
        cyc(0, 1, 3'd0, -7, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) cyc(0, 1, 3'd0, -10, 0);
            cyc(0, 0, 3'd0, 0, 1);
            total++;
            if (ifc.heading !== 16'(e[i]) || ifc.done !== (i == 1 || i == 3)) begin
                bad++;
                $display("FAIL ccw%0d got h=%0d d=%0b want h=%0d d=%0b",
                         i, ifc.heading, ifc.done, e[i], (i == 1 || i == 3));
            end
        end
    endtask

    task automatic test_zero();
        cyc(0, 1, 3'd0, 0, 1);
        total++;
        if (ifc.done !== 1'b1 || ifc.busy !== 1'b0 || ifc.heading !== 16'd353 || ifc.overrun !== 1'b0) begin
            bad++;
            $display("FAIL zero_pulse got d=%0b b=%0b h=%0d o=%0b want d=1 b=0 h=353 o=0",
                     ifc.done, ifc.busy, ifc.heading, ifc.overrun);
        end
        cyc(0, 0, 3'd0, 0, 1);
        total++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.heading !== 16'd353) begin
            bad++;
            $display("FAIL zero_after got d=%0b b=%0b h=%0d want d=0 b=0 h=353", ifc.done, ifc.busy, ifc.heading);
        end
    endtask

    task automatic test_overrun();
        cyc(0, 1, 3'd0, 8, 0);
        cyc(0, 1, 3'd0, -4, 1);
        total++;
        if (ifc.overrun !== 1'b1 || ifc.heading !== 16'd353 || ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
            bad++;
            $display("FAIL ovr_pulse got o=%0b h=%0d b=%0b d=%0b want o=1 h=353 b=1 d=0",
                     ifc.overrun, ifc.heading, ifc.busy, ifc.done);
        end
        cyc(0, 0, 3'd0, 0, 0);
        total++;
        if (ifc.overrun !== 1'b0 || ifc.heading !== 16'd353) begin
            bad++;
            $display("FAIL ovr_clear got o=%0b h=%0d want o=0 h=353", ifc.overrun, ifc.heading);
        end
        cyc(0, 0, 3'd0, 0, 1);
        total++;
        if (ifc.heading !== 16'd349 || ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
            bad++;
            $display("FAIL ovr_step got h=%0d d=%0b b=%0b want h=349 d=1 b=0", ifc.heading, ifc.done, ifc.busy);
        end
    endtask

    task automatic test_clamp_reset();
        cyc(1, 0, 3'd0, 0, 0);
        cyc(0, 1, 3'd0, 500, 0);
        for (int i = 0; i < 71; i++) cyc(0, 0, 3'd0, 0, 1);
        total++;
        if (ifc.heading !== 16'd355 || ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
            bad++;
            $display("FAIL clamp_71 got h=%0d b=%0b d=%0b want h=355 b=1 d=0", ifc.heading, ifc.busy, ifc.done);
        end
        cyc(0, 0, 3'd0, 0, 1);
        total++;
        if (ifc.heading !== 16'd359 || ifc.busy !== 1'b0 || ifc.done !== 1'b1) begin
            bad++;
            $display("FAIL clamp_72 got h=%0d b=%0b d=%0b want h=359 b=0 d=1", ifc.heading, ifc.busy, ifc.done);
        end
        cyc(0, 1, 3'd0, 500, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 3'd0, 0, 1);
        total++;
        if (ifc.heading !== 16'd44 || ifc.busy !== 1'b1) begin
            bad++;
            $display("FAIL clamp_pre_rst got h=%0d b=%0b want h=44 b=1", ifc.heading, ifc.busy);
        end
        cyc(1, 0, 3'd0, 0, 1);
        total++;
        if (ifc.heading !== 16'd0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_rst got h=%0d b=%0b d=%0b want h=0 b=0 d=0", ifc.heading, ifc.busy, ifc.done);
        end
        cyc(0, 0, 3'd0, 0, 1);
        total++;
        if (ifc.heading !== 16'd0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_after got h=%0d b=%0b d=%0b want h=0 b=0 d=0", ifc.heading, ifc.busy, ifc.done);
        end
    endtask

`ifdef STEER_SCORE_EN
    task automatic test_score();
        logic [2:0] g[3] = '{3'b000, 3'b111, 3'b010};
        int         e[3] = '{3, 3, 4};
        cyc(1, 0, 3'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, g[i], 0, 0);
            total++;
            if (ifc.score !== 16'(e[i])) begin
                bad++;
                $display("FAIL score%0d got=%0d want=%0d", i, ifc.score, e[i]);
            end
        end
        for (int i = 0; i < 21845; i++) cyc(0, 1, 3'd4, 0, 0);
        total++;
        if (ifc.score !== 16'hFFFF) begin
            bad++;
            $display("FAIL score_sat got=%0d want=65535", ifc.score);
        end
        cyc(0, 1, 3'd0, 0, 0);
        total++;
        if (ifc.score !== 16'hFFFF) begin
            bad++;
            $display("FAIL score_hold got=%0d want=65535", ifc.score);
        end
    endtask
`endif

    task automatic test_random();
        bit         rs, jr, tk;
        logic [2:0] jo;
        int         jm;
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 199) == 0);
            jr = ($urandom_range(0, 9) == 0);
            tk = 1'($urandom_range(0, 1));
            jo = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       jm = 0;
                1, 2:    jm = int'($urandom_range(0, 60)) - 30;
                default: jm = int'($signed(16'($urandom())));
            endcase
            cyc(rs, jr, jo, jm, tk);
            total++;
            if (ifc.heading !== 16'(m_head) || ifc.busy !== m_busy || ifc.done !== m_done ||
                ifc.overrun !== m_ovr || ifc.heading >= 16'd360) begin
                bad++;
                $display("FAIL rand%0d got h=%0d b=%0b d=%0b o=%0b want h=%0d b=%0b d=%0b o=%0b",
                         i, ifc.heading, ifc.busy, ifc.done, ifc.overrun, m_head, m_busy, m_done, m_ovr);
            end
`ifdef STEER_SCORE_EN
            total++;
            if (ifc.score !== 16'(m_score)) begin
                bad++;
                $display("FAIL rand_score%0d got=%0d want=%0d", i, ifc.score, m_score);
            end
`endif
        end
    endtask

    initial begin
        ifc.judge_ready = 1'b0;
        ifc.judge_out   = 3'd0;
        ifc.judge_modi  = 16'sd0;
        ifc.tick        = 1'b0;
        test_reset();
        test_cw();
        test_wrap();
        test_ccw();
        test_zero();
        test_overrun();
        test_clamp_reset();
`ifdef STEER_SCORE_EN
        test_score();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
